// File: rtl/plic_pkg.sv
// plic_pkg -- shared definitions for the PLIC claim arbiter slice.
//   PRIO_W_DEFAULT : default priority width in bits
//   ADDR_*         : register byte offsets (priority[i] lives at 4*i, i >= 1)
//   reg_sel_e      : decoded register target of a bus access
//   decode_addr()  : maps a byte address to a register target
package plic_pkg;

  localparam int unsigned PRIO_W_DEFAULT = 3;

  localparam logic [6:0] ADDR_PENDING = 7'h40;
  localparam logic [6:0] ADDR_ENABLE  = 7'h44;
  localparam logic [6:0] ADDR_THRESH  = 7'h48;
  localparam logic [6:0] ADDR_CLAIM   = 7'h4C;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PRIO,
    SEL_PENDING,
    SEL_ENABLE,
    SEL_THRESH,
    SEL_CLAIM
  } reg_sel_e;

  // Misaligned addresses and priority slots beyond nsrc decode as unmapped.
  function automatic reg_sel_e decode_addr(input logic [6:0] addr, input int unsigned nsrc);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr[1:0] == 2'b00) begin
      case (addr)
        ADDR_PENDING: sel = SEL_PENDING;
        ADDR_ENABLE:  sel = SEL_ENABLE;
        ADDR_THRESH:  sel = SEL_THRESH;
        ADDR_CLAIM:   sel = SEL_CLAIM;
        default: begin
          if ((addr < ADDR_PENDING) && (addr[6:2] != 5'd0) && (32'(addr[6:2]) <= nsrc))
            sel = SEL_PRIO;
        end
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/plic_claim_arbiter_if.sv
// plic_claim_arbiter_if -- gateway handshake and register bus of the arbiter.
//   gw_valid    : per-source valid from the level gateways (bit i-1 = ID i)
//   gw_ready    : per-source ready back to the gateways
//   gw_complete : per-source one-cycle completion pulse
//   reg_wen/reg_ren/reg_addr/reg_wdata : register access request
//   reg_rdata/reg_rvalid               : registered read response
// Modports: master = bus/gateway side, slave = arbiter.
interface plic_claim_arbiter_if #(
  parameter int unsigned NSRC = 7
);
  logic [NSRC-1:0] gw_valid;
  logic [NSRC-1:0] gw_ready;
  logic [NSRC-1:0] gw_complete;
  logic            reg_wen;
  logic            reg_ren;
  logic [6:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            reg_rvalid;

  modport master (
    output gw_valid, reg_wen, reg_ren, reg_addr, reg_wdata,
    input  gw_ready, gw_complete, reg_rdata, reg_rvalid
  );

  modport slave (
    input  gw_valid, reg_wen, reg_ren, reg_addr, reg_wdata,
    output gw_ready, gw_complete, reg_rdata, reg_rvalid
  );
endinterface

// File: rtl/plic_max_tree.sv
// plic_max_tree -- combinational selection of the best eligible source.
//   eligible : per-source eligibility (bit i-1 = ID i)
//   prio     : per-source priority
//   best     : highest-priority eligible ID, lowest ID on ties, 0 if none
module plic_max_tree #(
  parameter int unsigned NSRC   = 7,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned ID_W   = $clog2(NSRC + 1)
) (
  input  logic [NSRC-1:0]             eligible,
  input  logic [NSRC-1:0][PRIO_W-1:0] prio,
  output logic [ID_W-1:0]             best
);

  logic [PRIO_W-1:0] best_prio;
  logic              found;

  // Scan upward with a strict compare so an equal priority never displaces
  // a lower ID already selected.
  always_comb begin
    best      = '0;
    best_prio = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (eligible[i] && (!found || (prio[i] > best_prio))) begin
        found     = 1'b1;
        best_prio = prio[i];
        best      = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/plic_claim_arbiter.sv
// plic_claim_arbiter -- single-context PLIC pending/enable/priority store with
// claim/complete handling.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : plic_claim_arbiter_if.slave (gateway handshake + register bus)
//   irq   : registered external interrupt request (best != 0)
// Register map: 4*i priority[i] (i=1..NSRC), 0x40 pending (RO), 0x44 enable,
// 0x48 threshold, 0x4C claim (read) / complete (write).
// Build option: define PLIC_THRESHOLD_EN to make threshold a PRIO_W-bit
// register; otherwise threshold is constant 0 and writes to it are ignored.
module plic_claim_arbiter
  import plic_pkg::*;
#(
  parameter int unsigned NSRC   = 7,
  parameter int unsigned PRIO_W = PRIO_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  plic_claim_arbiter_if.slave bus,
  output logic                irq
);

  localparam int unsigned ID_W = $clog2(NSRC + 1);

  logic [NSRC-1:0]             pending;
  logic [NSRC-1:0]             enable;
  logic [NSRC-1:0][PRIO_W-1:0] prio;
  logic [PRIO_W-1:0]           threshold;
  logic [NSRC-1:0]             eligible;
  logic [NSRC-1:0]             set_mask;
  logic [NSRC-1:0]             clr_mask;
  logic [NSRC-1:0]             cmp_mask;
  logic [NSRC-1:0]             prio_sel;
  logic [NSRC-1:0]             complete_q;
  logic [ID_W-1:0]             best;
  logic [31:0]                 rdata_n;
  logic [31:0]                 rdata_q;
  logic                        rvalid_q;
  reg_sel_e                    wsel;
  reg_sel_e                    rsel;

  assign wsel = bus.reg_wen ? decode_addr(bus.reg_addr, NSRC) : SEL_NONE;
  assign rsel = bus.reg_ren ? decode_addr(bus.reg_addr, NSRC) : SEL_NONE;

  assign bus.gw_ready    = ~pending;
  assign bus.gw_complete = complete_q;
  assign bus.reg_rdata   = rdata_q;
  assign bus.reg_rvalid  = rvalid_q;

  // A set can never hit the claimed source (its ready is low), so set and
  // clear masks are disjoint and may be applied together.
  assign set_mask = bus.gw_valid & ~pending;

  always_comb begin
    eligible = '0;
    prio_sel = '0;
    clr_mask = '0;
    cmp_mask = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      eligible[i] = pending[i] & enable[i] & (prio[i] > threshold);
      prio_sel[i] = (32'(bus.reg_addr[6:2]) == (i + 1));
      if ((rsel == SEL_CLAIM) && (32'(best) == (i + 1)))
        clr_mask[i] = 1'b1;
      if ((wsel == SEL_CLAIM) && (bus.reg_wdata == (i + 1)))
        cmp_mask[i] = 1'b1;
    end
  end

  plic_max_tree #(
    .NSRC   (NSRC),
    .PRIO_W (PRIO_W),
    .ID_W   (ID_W)
  ) u_max_tree (
    .eligible (eligible),
    .prio     (prio),
    .best     (best)
  );

  // Read data is taken from pre-edge state, so a simultaneous write to the
  // same register is seen only by later reads.
  always_comb begin
    rdata_n = '0;
    case (rsel)
      SEL_PRIO: begin
        for (int unsigned i = 0; i < NSRC; i++)
          if (prio_sel[i]) rdata_n = 32'(prio[i]);
      end
      SEL_PENDING: rdata_n = 32'(pending);
      SEL_ENABLE:  rdata_n = 32'(enable);
      SEL_THRESH:  rdata_n = 32'(threshold);
      SEL_CLAIM:   rdata_n = 32'(best);
      default:     rdata_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      enable     <= '0;
      prio       <= '0;
      irq        <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      complete_q <= '0;
    end else begin
      pending    <= (pending | set_mask) & ~clr_mask;
      irq        <= (best != '0);
      rvalid_q   <= bus.reg_ren;
      complete_q <= cmp_mask;
      if (bus.reg_ren)
        rdata_q <= rdata_n;
      if (wsel == SEL_ENABLE)
        enable <= bus.reg_wdata[NSRC-1:0];
      for (int unsigned i = 0; i < NSRC; i++)
        if ((wsel == SEL_PRIO) && prio_sel[i])
          prio[i] <= bus.reg_wdata[PRIO_W-1:0];
    end
  end

`ifdef PLIC_THRESHOLD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      threshold <= '0;
    else if (wsel == SEL_THRESH)
      threshold <= bus.reg_wdata[PRIO_W-1:0];
  end
`else
  assign threshold = '0;
`endif

endmodule

// File: doc/plic_claim_arbiter.md
PLIC_CLAIM_ARBITER -- requirements
Module: plic_claim_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 7: number of interrupt sources, IDs 1..NSRC; ID 0 means "none".
REQ-002 SHALL have parameter PRIO_W, default 3: priority width in bits.
REQ-003 SHALL have port clk  input  1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port gw_valid  input  NSRC: per-source valid from the level gateways; bit i-1 maps to ID i.
REQ-006 SHALL have port gw_ready  output  NSRC: per-source ready to the gateways.
REQ-007 SHALL have port gw_complete  output  NSRC: per-source one-cycle completion pulse to the gateways.
REQ-008 SHALL have port reg_wen  input  1: register write strobe.
REQ-009 SHALL have port reg_ren  input  1: register read strobe.
REQ-010 SHALL have port reg_addr  input  7: byte address, word aligned.
REQ-011 SHALL have port reg_wdata  input  32: write data.
REQ-012 SHALL have port reg_rdata  output  32: read data, registered.
REQ-013 SHALL have port reg_rvalid  output  1: reg_rdata valid, one cycle after reg_ren.
REQ-014 SHALL have port irq  output  1: external interrupt request to the hart.

Function
REQ-015 SHALL map registers as follows: 0x04*i = priority[i] for i=1..NSRC (PRIO_W bits); 0x40 = pending bitmap (read-only); 0x44 = enable bitmap; 0x48 = threshold; 0x4C = claim (read) / complete (write).
REQ-016 SHALL drive gw_ready[i] = ~pending[i] combinationally, and SHALL set pending[i] on the edge where gw_valid[i] & gw_ready[i].
REQ-017 SHALL treat source i as eligible when pending[i] & enable[i] & (priority[i] > threshold); priority 0 is never eligible.
REQ-018 SHALL compute best = the highest-priority eligible ID, with ties going to the lowest ID, or 0 if none are eligible.
REQ-019 SHALL register irq = (best != 0), so irq follows a pending, enable, priority or threshold change with exactly one cycle of latency.
REQ-020 SHALL, on reg_ren to 0x4C, return best as evaluated in that cycle in reg_rdata on the next cycle, and clear pending[best] on the same edge when best != 0.
REQ-021 SHALL, on reg_wen to 0x4C with wdata in 1..NSRC, pulse gw_complete[wdata] high for exactly one cycle starting the next cycle; other values SHALL be ignored.
REQ-022 SHALL accept a complete for an ID regardless of its enable bit.
REQ-023 SHALL apply a claim clear and a pending set in the same cycle when they target different sources; a set to the claimed source is impossible because gw_ready is low.
REQ-024 SHALL, when reg_wen and reg_ren occur in the same cycle, return the pre-write value from the read and apply the write.
REQ-025 SHALL return 0 for reads of unmapped addresses, and SHALL ignore writes to unmapped addresses and to 0x40.
REQ-026 SHALL assert reg_rvalid for exactly one cycle per reg_ren.

Reset
REQ-027 SHALL clear, on reset assertion (asynchronous): pending, priority, enable, threshold, irq, reg_rdata, reg_rvalid and gw_complete to 0; gw_ready is therefore all ones.
REQ-028 SHALL abort a claim or complete in progress when reset is asserted mid-operation, and SHALL emit no pulse after reset release.

Configuration
REQ-029 SHALL, with PLIC_THRESHOLD_EN defined, implement threshold at 0x48 as a PRIO_W-bit read/write register used in REQ-017.
REQ-030 SHALL, without PLIC_THRESHOLD_EN, fix threshold at constant 0, read 0x48 as 0 and ignore writes to it.

Structure
REQ-031 SHALL take register offsets (0x40/0x44/0x48/0x4C) and the default PRIO_W from the shared package plic_pkg.
REQ-032 SHALL place best selection in sub-module plic_max_tree, a combinational priority/ID comparator tree over NSRC sources.

Verification
REQ-033 SHALL cover: prio[3]=5, enable=0x04, gw_valid[2] pulse -> gw_ready[2]=0 next cycle, irq=1 one cycle later; claim read -> rdata=3, pending=0, irq=0.
REQ-034 SHALL cover: prio[1]=4, prio[5]=4, prio[6]=6, all pending and enabled -> claims return 6, then 1, then 5, then 0.
REQ-035 SHALL cover: write 0x4C=3 -> gw_complete=0b0000100 for one cycle; write 0x4C=9 -> no pulse.
REQ-036 SHALL cover, with PLIC_THRESHOLD_EN: threshold=5, prio[2]=5 pending -> irq=0; threshold=4 -> irq=1 one cycle later. Without the macro: read 0x48 -> 0.
REQ-037 SHALL cover: reset asserted mid-cycle with pending=0x7F -> pending, irq and gw_complete clear immediately, gw_ready=0x7F.
